// File: rtl/ts_buffer_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing the packet buffer write port between two writers; optional watchdog via PKT_ARB_TIMEOUT_EN.
// Latency: grant one cycle after wr in IDLE, next word one cycle after owner wr in HOLD; acks are combinational with i_wdata_ack.
// Backpressure: o_data_wr is held with frozen data until i_wdata_ack; non-owners wait (no ack) until the owner's tail is accepted.
module ts_buffer_write_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [133:0] iv_req0_wdata,
    input  logic         i_req0_wr,
    input  logic [15:0]  iv_req0_waddr,
    output logic         o_req0_ack,
    input  logic [133:0] iv_req1_wdata,
    input  logic         i_req1_wr,
    input  logic [15:0]  iv_req1_waddr,
    output logic         o_req1_ack,
    output logic [133:0] ov_wdata,
    output logic         o_data_wr,
    output logic [15:0]  ov_data_waddr,
    input  logic         i_wdata_ack,
    output logic         o_timeout_err,
    output logic [1:0]   ov_arb_state,
    output logic [15:0]  ov_req0_pkt_cnt,
    output logic [15:0]  ov_req1_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           owner, owner_nxt;
    logic           last_grant, last_grant_nxt;
    logic [133:0]   wdata_nxt;
    logic [15:0]    waddr_nxt;
    logic           data_wr_nxt;
    logic [15:0]    cnt0_nxt, cnt1_nxt;
    logic           timeout_err_nxt;
    logic           gnt_sel;
    logic           own_wr;
    logic [133:0]   own_wdata;
    logic [15:0]    own_waddr;

`ifdef PKT_ARB_TIMEOUT_EN
    logic [15:0]    to_cnt, to_cnt_nxt;
`else
    logic [15:0]    unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    // On a tie the requester that did not win last time is granted.
    assign gnt_sel   = (i_req0_wr & i_req1_wr) ? ~last_grant : i_req1_wr;
    assign own_wr    = owner ? i_req1_wr     : i_req0_wr;
    assign own_wdata = owner ? iv_req1_wdata : iv_req0_wdata;
    assign own_waddr = owner ? iv_req1_waddr : iv_req0_waddr;

    assign o_req0_ack   = i_wdata_ack & o_data_wr & ~owner;
    assign o_req1_ack   = i_wdata_ack & o_data_wr &  owner;
    assign ov_arb_state = state;

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_grant_nxt  = last_grant;
        wdata_nxt       = ov_wdata;
        waddr_nxt       = ov_data_waddr;
        data_wr_nxt     = o_data_wr;
        cnt0_nxt        = ov_req0_pkt_cnt;
        cnt1_nxt        = ov_req1_pkt_cnt;
        timeout_err_nxt = 1'b0;
`ifdef PKT_ARB_TIMEOUT_EN
        to_cnt_nxt      = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (i_req0_wr | i_req1_wr) begin
                    owner_nxt   = gnt_sel;
                    wdata_nxt   = gnt_sel ? iv_req1_wdata : iv_req0_wdata;
                    waddr_nxt   = gnt_sel ? iv_req1_waddr : iv_req0_waddr;
                    data_wr_nxt = 1'b1;
                    state_nxt   = FWD;
                end
            end
            FWD: begin
                if (i_wdata_ack) begin
                    data_wr_nxt = 1'b0;
                    if (ov_wdata[133:132] == 2'b10) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = owner;
                        if (owner) cnt1_nxt = ov_req1_pkt_cnt + 16'd1;
                        else       cnt0_nxt = ov_req0_pkt_cnt + 16'd1;
                    end else begin
                        state_nxt = HOLD;
`ifdef PKT_ARB_TIMEOUT_EN
                        to_cnt_nxt = 16'd0;
`endif
                    end
                end
            end
            HOLD: begin
                if (own_wr) begin
                    wdata_nxt   = own_wdata;
                    waddr_nxt   = own_waddr;
                    data_wr_nxt = 1'b1;
                    state_nxt   = FWD;
                end
`ifdef PKT_ARB_TIMEOUT_EN
                // Stalled owner loses the port and its packet is not counted.
                else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                    last_grant_nxt  = owner;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            ov_wdata        <= '0;
            ov_data_waddr   <= '0;
            o_data_wr       <= 1'b0;
            ov_req0_pkt_cnt <= '0;
            ov_req1_pkt_cnt <= '0;
            o_timeout_err   <= 1'b0;
`ifdef PKT_ARB_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            state           <= state_nxt;
            owner           <= owner_nxt;
            last_grant      <= last_grant_nxt;
            ov_wdata        <= wdata_nxt;
            ov_data_waddr   <= waddr_nxt;
            o_data_wr       <= data_wr_nxt;
            ov_req0_pkt_cnt <= cnt0_nxt;
            ov_req1_pkt_cnt <= cnt1_nxt;
            o_timeout_err   <= timeout_err_nxt;
`ifdef PKT_ARB_TIMEOUT_EN
            to_cnt          <= to_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ts_buffer_write_arbiter.sv
// Directed table-driven bench for ts_buffer_write_arbiter plus fairness and watchdog sequences.
module tb_ts_buffer_write_arbiter;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] M = 2'b11;
    localparam logic [1:0] T = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [133:0] req0_wdata, req1_wdata;
    logic         req0_wr, req1_wr;
    logic [15:0]  req0_waddr, req1_waddr;
    logic         req0_ack, req1_ack;
    logic [133:0] wdata;
    logic         data_wr;
    logic [15:0]  data_waddr;
    logic         wdata_ack;
    logic         timeout_err;
    logic [1:0]   arb_state;
    logic [15:0]  pkt_cnt0, pkt_cnt1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ts_buffer_write_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .iv_req0_wdata   (req0_wdata),
        .i_req0_wr       (req0_wr),
        .iv_req0_waddr   (req0_waddr),
        .o_req0_ack      (req0_ack),
        .iv_req1_wdata   (req1_wdata),
        .i_req1_wr       (req1_wr),
        .iv_req1_waddr   (req1_waddr),
        .o_req1_ack      (req1_ack),
        .ov_wdata        (wdata),
        .o_data_wr       (data_wr),
        .ov_data_waddr   (data_waddr),
        .i_wdata_ack     (wdata_ack),
        .o_timeout_err   (timeout_err),
        .ov_arb_state    (arb_state),
        .ov_req0_pkt_cnt (pkt_cnt0),
        .ov_req1_pkt_cnt (pkt_cnt1)
    );

    typedef struct packed {
        logic [1:0]  chk;   // 0 skip, 1 control, 2 control + data regardless of strobe
        logic        rst;
        logic        w0;
        logic [1:0]  t0;
        logic [15:0] a0;
        logic        w1;
        logic [1:0]  t1;
        logic [15:0] a1;
        logic        ack;
        logic        e_wr;
        logic [1:0]  e_t;
        logic [15:0] e_a;
        logic        e_ack0;
        logic        e_ack1;
        logic [1:0]  e_st;
        logic [15:0] e_c0;
        logic [15:0] e_c1;
    } vec_t;

    vec_t vecs[27];

    function automatic logic [133:0] mk(input logic [1:0] t, input logic [15:0] a);
        return {t, 4'h0, {8{a}}};
    endfunction

    function automatic vec_t v(input logic [1:0] chk, input logic rst,
                               input logic w0, input logic [1:0] t0, input logic [15:0] a0,
                               input logic w1, input logic [1:0] t1, input logic [15:0] a1,
                               input logic ack, input logic e_wr, input logic [1:0] e_t,
                               input logic [15:0] e_a, input logic e_ack0, input logic e_ack1,
                               input logic [1:0] e_st, input logic [15:0] e_c0, input logic [15:0] e_c1);
        vec_t r;
        r = {chk, rst, w0, t0, a0, w1, t1, a1, ack, e_wr, e_t, e_a, e_ack0, e_ack1, e_st, e_c0, e_c1};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic rst, input logic w0, input logic [1:0] t0, input logic [15:0] a0,
                         input logic w1, input logic [1:0] t1, input logic [15:0] a1, input logic ack);
        rst_n      = rst;
        req0_wr    = w0;
        req0_wdata = mk(t0, a0);
        req0_waddr = a0;
        req1_wr    = w1;
        req1_wdata = mk(t1, a1);
        req1_waddr = a1;
        wdata_ack  = ack;
    endtask

    initial begin
        int grants;
        int cyc;
        // single requester 0: head/middle/tail, RAM acks 2 cycles after the strobe
        vecs[0]  = v(2,1, 1,H,16'h0100, 0,H,16'h0000, 0,  0,2'b00,16'h0000, 0,0, 0, 0,0);
        vecs[1]  = v(1,1, 1,H,16'h0100, 0,H,16'h0000, 0,  1,H,16'h0100,     0,0, 1, 0,0);
        vecs[2]  = v(1,1, 1,H,16'h0100, 0,H,16'h0000, 0,  1,H,16'h0100,     0,0, 1, 0,0);
        vecs[3]  = v(1,1, 1,H,16'h0100, 0,H,16'h0000, 1,  1,H,16'h0100,     1,0, 1, 0,0);
        vecs[4]  = v(1,1, 1,M,16'h0101, 0,H,16'h0000, 0,  0,M,16'h0101,     0,0, 2, 0,0);
        vecs[5]  = v(1,1, 1,M,16'h0101, 0,H,16'h0000, 0,  1,M,16'h0101,     0,0, 1, 0,0);
        vecs[6]  = v(1,1, 1,M,16'h0101, 0,H,16'h0000, 0,  1,M,16'h0101,     0,0, 1, 0,0);
        vecs[7]  = v(1,1, 1,M,16'h0101, 0,H,16'h0000, 1,  1,M,16'h0101,     1,0, 1, 0,0);
        vecs[8]  = v(1,1, 1,T,16'h0102, 0,H,16'h0000, 0,  0,T,16'h0102,     0,0, 2, 0,0);
        vecs[9]  = v(1,1, 1,T,16'h0102, 0,H,16'h0000, 0,  1,T,16'h0102,     0,0, 1, 0,0);
        vecs[10] = v(1,1, 1,T,16'h0102, 0,H,16'h0000, 0,  1,T,16'h0102,     0,0, 1, 0,0);
        vecs[11] = v(1,1, 1,T,16'h0102, 0,H,16'h0000, 1,  1,T,16'h0102,     1,0, 1, 0,0);
        vecs[12] = v(1,1, 0,T,16'h0102, 0,H,16'h0000, 0,  0,T,16'h0102,     0,0, 0, 1,0);
        // tie right after reset, then atomicity with req0 interloping on req1's packet
        vecs[13] = v(0,0, 0,H,16'h0000, 0,H,16'h0000, 0,  0,2'b00,16'h0000, 0,0, 0, 0,0);
        vecs[14] = v(2,1, 1,T,16'h0200, 1,H,16'h0300, 0,  0,2'b00,16'h0000, 0,0, 0, 0,0);
        vecs[15] = v(1,1, 1,T,16'h0200, 1,H,16'h0300, 1,  1,T,16'h0200,     1,0, 1, 0,0);
        vecs[16] = v(1,1, 0,T,16'h0200, 1,H,16'h0300, 0,  0,T,16'h0200,     0,0, 0, 1,0);
        vecs[17] = v(1,1, 0,T,16'h0200, 1,H,16'h0300, 1,  1,H,16'h0300,     0,1, 1, 1,0);
        vecs[18] = v(2,1, 1,H,16'h0210, 0,H,16'h0300, 0,  0,H,16'h0300,     0,0, 2, 1,0);
        vecs[19] = v(2,1, 1,H,16'h0210, 0,H,16'h0300, 1,  0,H,16'h0300,     0,0, 2, 1,0);
        vecs[20] = v(2,1, 1,H,16'h0210, 1,T,16'h0301, 0,  0,H,16'h0300,     0,0, 2, 1,0);
        vecs[21] = v(1,1, 1,H,16'h0210, 1,T,16'h0301, 1,  1,T,16'h0301,     0,1, 1, 1,0);
        vecs[22] = v(1,1, 1,H,16'h0210, 0,T,16'h0301, 0,  0,T,16'h0301,     0,0, 0, 1,1);
        vecs[23] = v(1,1, 1,H,16'h0210, 0,T,16'h0301, 0,  1,H,16'h0210,     0,0, 1, 1,1);
        // reset while in FWD
        vecs[24] = v(0,0, 1,H,16'h0210, 0,T,16'h0301, 0,  0,2'b00,16'h0000, 0,0, 0, 0,0);
        vecs[25] = v(2,1, 1,T,16'h0220, 1,T,16'h0310, 0,  0,2'b00,16'h0000, 0,0, 0, 0,0);
        vecs[26] = v(1,1, 1,T,16'h0220, 1,T,16'h0310, 1,  1,T,16'h0220,     1,0, 1, 0,0);

        drive(0, 0,H,16'h0, 0,H,16'h0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].w0, vecs[i].t0, vecs[i].a0,
                  vecs[i].w1, vecs[i].t1, vecs[i].a1, vecs[i].ack);
            @(negedge clk);
            if (vecs[i].chk != 2'd0) begin
                chk($sformatf("row%0d_wr", i),    134'(data_wr),     134'(vecs[i].e_wr));
                chk($sformatf("row%0d_ack0", i),  134'(req0_ack),    134'(vecs[i].e_ack0));
                chk($sformatf("row%0d_ack1", i),  134'(req1_ack),    134'(vecs[i].e_ack1));
                chk($sformatf("row%0d_state", i), 134'(arb_state),   134'(vecs[i].e_st));
                chk($sformatf("row%0d_cnt0", i),  134'(pkt_cnt0),    134'(vecs[i].e_c0));
                chk($sformatf("row%0d_cnt1", i),  134'(pkt_cnt1),    134'(vecs[i].e_c1));
                chk($sformatf("row%0d_err", i),   134'(timeout_err), 134'(0));
                if (vecs[i].e_wr || vecs[i].chk == 2'd2) begin
                    chk($sformatf("row%0d_wdata", i), wdata, mk(vecs[i].e_t, vecs[i].e_a));
                    chk($sformatf("row%0d_waddr", i), 134'(data_waddr), 134'(vecs[i].e_a));
                end
            end
        end

        // fairness: both stream single-word packets, RAM always acking
        @(posedge clk); #1;
        drive(0, 0,T,16'h0, 0,T,16'h0, 0);
        @(posedge clk); #1;
        drive(1, 1,T,16'h0600, 1,T,16'h0700, 1);
        grants = 0;
        cyc    = 0;
        while (grants < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (data_wr) begin
                chk($sformatf("fair_addr%0d", grants), 134'(data_waddr),
                    134'((grants % 2 == 1) ? 16'h0700 : 16'h0600));
                chk($sformatf("fair_ack%0d", grants), 134'({req1_ack, req0_ack}),
                    134'((grants % 2 == 1) ? 2'b10 : 2'b01));
                grants++;
            end
        end
        chk("fair_grants", 134'(grants), 134'(10));
        @(posedge clk); #1;
        drive(1, 0,T,16'h0600, 0,T,16'h0700, 0);
        @(negedge clk);
        chk("fair_cnt0", 134'(pkt_cnt0), 134'(5));
        chk("fair_cnt1", 134'(pkt_cnt1), 134'(5));

        // watchdog: req0 stalls after its head word, req1 waits
        @(posedge clk); #1;
        drive(0, 0,H,16'h0, 0,H,16'h0, 0);
        @(posedge clk); #1;
        drive(1, 1,H,16'h0400, 1,H,16'h0500, 0);
        @(posedge clk); #1;
        wdata_ack = 1'b1;
        @(negedge clk);
        chk("wd_head_ack", 134'({req1_ack, req0_ack}), 134'(2'b01));
        @(posedge clk); #1;
        wdata_ack = 1'b0;
        req0_wr   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("wd_hold_state%0d", i), 134'(arb_state), 134'(2));
            chk($sformatf("wd_hold_err%0d", i), 134'(timeout_err), 134'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
`ifdef PKT_ARB_TIMEOUT_EN
        chk("wd_err_pulse", 134'(timeout_err), 134'(1));
        chk("wd_idle", 134'(arb_state), 134'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_err_clear", 134'(timeout_err), 134'(0));
        chk("wd_req1_wr", 134'(data_wr), 134'(1));
        chk("wd_req1_addr", 134'(data_waddr), 134'(16'h0500));
        chk("wd_cnt0", 134'(pkt_cnt0), 134'(0));
`else
        chk("wd_still_hold", 134'(arb_state), 134'(2));
        chk("wd_no_err", 134'(timeout_err), 134'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_still_hold2", 134'(arb_state), 134'(2));
        chk("wd_no_wr", 134'(data_wr), 134'(0));
        chk("wd_no_ack1", 134'(req1_ack), 134'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
